// File: rtl/mu0_pkg.sv
// mu0_pkg: shared widths, opcode encodings and controller state type for the
// MU0 accumulator CPU.
package mu0_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

endpackage

// File: rtl/mu0_if.sv
// mu0_if: single memory port between the MU0 core (master) and external memory
// (slave).
// Handshake: there is no valid/ready pair. memory_read and memory_write are
// one-cycle strobes, never both high. On a read, memory drives data_in
// combinationally from address in the same cycle. On a write, memory captures
// data_out at address on the rising edge that ends the cycle.
interface mu0_if;
  import mu0_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              memory_read;
  logic              memory_write;

  modport master (
    output address, data_out, memory_read, memory_write,
    input  data_in
  );

  modport slave (
    input  address, data_out, memory_read, memory_write,
    output data_in
  );
endinterface

// File: rtl/mu0_control.sv
// mu0_control: two-state fetch/execute FSM plus opcode decoder for MU0.
// Optional macro MU0_ILLEGAL_HALT_EN: opcodes 8-F halt the CPU instead of
// acting as no-ops.
module mu0_control
  import mu0_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode_i,
  input  logic       flag_n_i,
  input  logic       flag_z_i,
  output logic       memory_read_o,
  output logic       memory_write_o,
  output logic       fetch_o,
  output logic       pc_load_o,
  output logic       acc_load_o,
  output logic       acc_mem_o,
  output logic       alu_sub_o,
  output logic       halted_o,
  output state_t     state_o
);

  state_t state_q, state_d;
  logic   halted_q, halted_d;

  // State and halt registers; reset returns to a clean fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next state and per-cycle control strobes; a halted CPU parks in EXECUTE
  // with every strobe low, which freezes the whole datapath.
  always_comb begin
    state_d        = state_q;
    halted_d       = halted_q;
    memory_read_o  = 1'b0;
    memory_write_o = 1'b0;
    fetch_o        = 1'b0;
    pc_load_o      = 1'b0;
    acc_load_o     = 1'b0;
    acc_mem_o      = 1'b0;
    alu_sub_o      = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_o       = 1'b1;
        memory_read_o = 1'b1;
        state_d       = EXECUTE;
      end
      EXECUTE: begin
        if (!halted_q) begin
          state_d = FETCH;
          case (opcode_i)
            OP_LDA: begin
              memory_read_o = 1'b1;
              acc_load_o    = 1'b1;
              acc_mem_o     = 1'b1;
            end
            OP_STA: memory_write_o = 1'b1;
            OP_ADD: begin
              memory_read_o = 1'b1;
              acc_load_o    = 1'b1;
            end
            OP_SUB: begin
              memory_read_o = 1'b1;
              acc_load_o    = 1'b1;
              alu_sub_o     = 1'b1;
            end
            OP_JMP: pc_load_o = 1'b1;
            OP_JGE: pc_load_o = !flag_n_i;
            OP_JNE: pc_load_o = !flag_z_i;
            OP_STP: begin
              halted_d = 1'b1;
              state_d  = EXECUTE;
            end
            default: begin
`ifdef MU0_ILLEGAL_HALT_EN
              halted_d = 1'b1;
              state_d  = EXECUTE;
`endif
            end
          endcase
        end
      end
    endcase
  end

  assign halted_o = halted_q;
  assign state_o  = state_q;

endmodule

// File: rtl/mu0_core.sv
// mu0_core: MU0 16-bit accumulator CPU. It holds the PC, ACC and IR datapath
// and instantiates mu0_control. Memory is external and is reached through
// mu0_if. Optional macro MU0_ILLEGAL_HALT_EN is handled in mu0_control.
module mu0_core
  import mu0_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mu0_if.master             mem,
  output logic              fetch,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        flags,
  output state_t            dbg_state,
  output logic              halted
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] alu_res;
  logic flag_n, flag_z;
  logic pc_load, acc_load, acc_mem, alu_sub;

  assign flag_n = acc_q[DATA_W-1];
  assign flag_z = (acc_q == '0);

  mu0_control u_control (
    .clk            (clk),
    .rst            (rst),
    .opcode_i       (ir_q[15:12]),
    .flag_n_i       (flag_n),
    .flag_z_i       (flag_z),
    .memory_read_o  (mem.memory_read),
    .memory_write_o (mem.memory_write),
    .fetch_o        (fetch),
    .pc_load_o      (pc_load),
    .acc_load_o     (acc_load),
    .acc_mem_o      (acc_mem),
    .alu_sub_o      (alu_sub),
    .halted_o       (halted),
    .state_o        (dbg_state)
  );

  // Adder/subtractor, address mux and next-state values for PC, ACC and IR.
  always_comb begin
    alu_res = alu_sub ? (acc_q - mem.data_in) : (acc_q + mem.data_in);
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    if (fetch) begin
      ir_d = mem.data_in;
      pc_d = pc_q + 12'd1;
    end
    if (pc_load) pc_d = ir_q[ADDR_W-1:0];
    if (acc_load) acc_d = acc_mem ? mem.data_in : alu_res;
  end

  // Datapath registers; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      acc_q <= '0;
      ir_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
      ir_q  <= ir_d;
    end
  end

  assign mem.address  = fetch ? pc_q : ir_q[ADDR_W-1:0];
  assign mem.data_out = acc_q;
  assign acc          = acc_q;
  assign pc           = pc_q;
  assign flags        = {flag_n, flag_z};

endmodule

// File: tb/tb_mu0_core.sv
// tb_mu0_core: runs directed and random MU0 programs against an
// instruction-level reference interpreter.
module tb_mu0_core;
  import mu0_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mu0_if bus ();

  logic        fetch, halted;
  logic [15:0] acc;
  logic [11:0] pc;
  logic [1:0]  flags;
  state_t      dbg_state;

  mu0_core dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .fetch     (fetch),
    .acc       (acc),
    .pc        (pc),
    .flags     (flags),
    .dbg_state (dbg_state),
    .halted    (halted)
  );

  // Memory model: combinational read, write on the rising edge, bulk load from prog
  logic [15:0] mem  [4096];
  logic [15:0] prog [4096];
  logic        load_req = 1'b0;

  assign bus.data_in = mem[bus.address];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= prog[i];
    end else if (bus.memory_write) begin
      mem[bus.address] <= bus.data_out;
    end
  end

  // Reference interpreter state and scoreboard
  logic [15:0] ref_mem [4096];
  logic [11:0] ref_pc;
  logic [15:0] ref_acc;
  logic        ref_halted;
  logic [27:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) prog[i] = 16'h0000;
  endtask

  // Reset the DUT, load prog into memory and restart the reference model
  task automatic do_reset();
    rst        = 1'b1;
    load_req   = 1'b1;
    ref_mem    = prog;
    ref_pc     = 12'h000;
    ref_acc    = 16'h0000;
    ref_halted = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst      = 1'b0;
    load_req = 1'b0;
    check("rst_pc", pc, 12'h000);
    check("rst_acc", acc, 16'h0000);
    check("rst_flags", flags, 2'b01);
    check("rst_fetch", fetch, 1'b1);
    check("rst_addr", bus.address, 12'h000);
    check("rst_rd", bus.memory_read, 1'b1);
    check("rst_state", dbg_state, FETCH);
  endtask

  // One instruction in lockstep: the reference steps, then the DUT runs two cycles
  task automatic exec_one();
    logic [15:0] ir;
    logic [3:0]  op;
    logic [11:0] s;
    logic        exp_wr, exp_rd;
    logic [27:0] w;
    check("f_fetch", fetch, 1'b1);
    check("f_addr", bus.address, ref_pc);
    check("f_rd", bus.memory_read, 1'b1);
    check("f_wr", bus.memory_write, 1'b0);
    ir     = ref_mem[ref_pc];
    op     = ir[15:12];
    s      = ir[11:0];
    ref_pc = ref_pc + 12'd1;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    case (op)
      4'h0: begin exp_rd = 1'b1; ref_acc = ref_mem[s]; end
      4'h1: begin exp_wr = 1'b1; ref_mem[s] = ref_acc; exp_q.push_back({s, ref_acc}); end
      4'h2: begin exp_rd = 1'b1; ref_acc = ref_acc + ref_mem[s]; end
      4'h3: begin exp_rd = 1'b1; ref_acc = ref_acc - ref_mem[s]; end
      4'h4: ref_pc = s;
      4'h5: if ($signed(ref_acc) >= 0) ref_pc = s;
      4'h6: if (ref_acc != 16'h0000) ref_pc = s;
      4'h7: ref_halted = 1'b1;
      default: begin
`ifdef MU0_ILLEGAL_HALT_EN
        ref_halted = 1'b1;
`endif
      end
    endcase
    @(posedge clk); #1;
    check("x_fetch", fetch, 1'b0);
    check("x_addr", bus.address, s);
    check("x_rd", bus.memory_read, exp_rd);
    check("x_wr", bus.memory_write, exp_wr);
    if (exp_wr) begin
      w = exp_q.pop_front();
      check("x_wdata", {bus.address, bus.data_out}, w);
    end
    @(posedge clk); #1;
    check("pc", pc, ref_pc);
    check("acc", acc, ref_acc);
    check("flags", flags, {ref_acc[15], ref_acc == 16'h0000});
  endtask

  task automatic halt_check();
    repeat (4) begin
      @(posedge clk); #1;
      check("h_fetch", fetch, 1'b0);
      check("h_rd", bus.memory_read, 1'b0);
      check("h_wr", bus.memory_write, 1'b0);
      check("h_pc", pc, ref_pc);
      check("h_acc", acc, ref_acc);
    end
  endtask

  task automatic run_prog(input int max_instr);
    for (int i = 0; i < max_instr && !ref_halted; i++) exec_one();
    if (ref_halted) halt_check();
  endtask

  initial begin
    logic [3:0]  op;
    logic [11:0] s;

    // LDA/ADD/STA then STP
    clear_prog();
    prog[0] = 16'h0010; prog[1] = 16'h2011; prog[2] = 16'h1012; prog[3] = 16'h7000;
    prog[12'h010] = 16'h0005; prog[12'h011] = 16'h0007;
    do_reset();
    run_prog(10);
    check("add_mem12", mem[12'h012], 16'h000C);
    check("add_pc", pc, 12'h004);
    check("add_fetch", fetch, 1'b0);

    // SUB to negative, then JGE not taken
    clear_prog();
    prog[0] = 16'h0010; prog[1] = 16'h3011; prog[2] = 16'h5020; prog[3] = 16'h7000;
    prog[12'h010] = 16'h0003; prog[12'h011] = 16'h0005;
    do_reset();
    exec_one(); exec_one();
    check("sub_acc", acc, 16'hFFFE);
    check("sub_flags", flags, 2'b10);
    exec_one();
    check("jge_nt_pc", pc, 12'h003);
    run_prog(2);

    // JNE not taken, JNE taken, JMP
    clear_prog();
    prog[0] = 16'h0010; prog[1] = 16'h6050; prog[2] = 16'h0011; prog[3] = 16'h6050;
    prog[12'h010] = 16'h0000; prog[12'h011] = 16'h0001;
    prog[12'h050] = 16'h43FF; prog[12'h3FF] = 16'h7000;
    do_reset();
    exec_one(); exec_one();
    check("jne_nt_pc", pc, 12'h002);
    exec_one(); exec_one();
    check("jne_t_pc", pc, 12'h050);
    exec_one();
    check("jmp_addr", bus.address, 12'h3FF);
    run_prog(2);

    // GCD(0x30, 0x12) by repeated subtraction
    clear_prog();
    prog[0]  = 16'h0030; prog[1]  = 16'h3031; prog[2]  = 16'h6004; prog[3]  = 16'h400B;
    prog[4]  = 16'h5009; prog[5]  = 16'h0031; prog[6]  = 16'h3030; prog[7]  = 16'h1031;
    prog[8]  = 16'h4000; prog[9]  = 16'h1030; prog[10] = 16'h4000; prog[11] = 16'h0030;
    prog[12] = 16'h1032; prog[13] = 16'h7000;
    prog[12'h030] = 16'h0030; prog[12'h031] = 16'h0012;
    do_reset();
    run_prog(100);
    check("gcd_halted", fetch, 1'b0);
    check("gcd_result", mem[12'h032], 16'h0006);

    // Reset during an STA execute cycle
    clear_prog();
    prog[0] = 16'h0010; prog[1] = 16'h1020; prog[12'h010] = 16'h1234;
    do_reset();
    exec_one();
    @(posedge clk); #1;
    check("mr_wr", bus.memory_write, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_fetch", fetch, 1'b1);
    check("mr_pc", pc, 12'h000);
    check("mr_acc", acc, 16'h0000);
    check("mr_addr", bus.address, 12'h000);
    check("mr_mem", mem[12'h020], 16'h1234);

    // PC wrap from a fetch at 0xFFF
    clear_prog();
    prog[0] = 16'h4FFF; prog[12'hFFF] = 16'h0010; prog[12'h010] = 16'h4321;
    do_reset();
    exec_one(); exec_one();
    check("wrap_pc", pc, 12'h000);
    check("wrap_acc", acc, 16'h4321);

    // Random programs in a 64-word region shared by code and data
    for (int r = 0; r < 8; r++) begin
      clear_prog();
      for (int i = 0; i < 64; i++) begin
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        s  = 12'($urandom_range(0, 63));
        prog[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {op, s};
      end
      do_reset();
      run_prog(150);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
